modulo_batalha_grid_ctrl: RTL and testbench

//  Parametrised battleship game core: a ROWS x COLS ship map, an attack register with per-shot hit/miss judgement,
//  and shot/win/lose tracking. Also scans the LED matrix column by column and time-multiplexes the 7-seg digit data.

---
 rtl/modulo_batalha_grid_ctrl_pkg.sv | 27 ++
 rtl/modulo_batalha_grid_ctrl_if.sv | 37 +++
 rtl/modulo_contador_div.sv | 23 ++
 rtl/modulo_batalha_grid_ctrl.sv | 177 +++++++++++++++++
 tb/tb_modulo_batalha_grid_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/modulo_batalha_grid_ctrl_pkg.sv
// Shared status codes, FSM states and cell indexing for the battleship grid controller.
package modulo_batalha_grid_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MISS    = 3'd1,
        ST_HIT     = 3'd2,
        ST_REPEAT  = 3'd3,
        ST_INVALID = 3'd4,
        ST_WIN     = 3'd5,
        ST_LOSE    = 3'd6
    } status_e;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } game_state_e;

    localparam int SYNC_DEPTH = 2;
    localparam int NUM_DIGITS = 3;

    // Cell (r,c), both 1-based, lives at the MSB end of the flat map for (1,1).
    function automatic int cell_bit(input int rows, input int cols, input int r, input int c);
        return rows * cols - 1 - ((r - 1) * cols + (c - 1));
    endfunction

endpackage

// File: rtl/modulo_batalha_grid_ctrl_if.sv
// Game inputs and display/status outputs of the battleship core, bundled as one port.
interface modulo_batalha_grid_ctrl_if
    import modulo_batalha_grid_ctrl_pkg::*;
#(
    parameter int ROWS = 7,
    parameter int COLS = 5,
    parameter int RW   = 3,
    parameter int CW   = 3
);
    // confirm/clear are raw level buttons with no ready back-pressure: the core
    // synchronises and edge-detects them, so one press is one action however long it is held.
    logic [ROWS*COLS-1:0] ship_map;
    logic [RW-1:0]        coord_row;
    logic [CW-1:0]        coord_col;
    logic                 confirm;
    logic                 clear;
    logic                 show_ships;
    logic [COLS-1:0]      m_col;
    logic [ROWS-1:0]      m_line;
    logic [1:0]           digit_sel;
    logic [3:0]           digit_val;
    logic [2:0]           status;
    logic [7:0]           shots;
    logic                 game_over;
    game_state_e          fsm_state;

    modport master (
        output ship_map, coord_row, coord_col, confirm, clear, show_ships,
        input  m_col, m_line, digit_sel, digit_val, status, shots, game_over, fsm_state
    );

    modport slave (
        input  ship_map, coord_row, coord_col, confirm, clear, show_ships,
        output m_col, m_line, digit_sel, digit_val, status, shots, game_over, fsm_state
    );

endinterface

// File: rtl/modulo_contador_div.sv
// Wrap counter 0..N-1 that advances when en is high; tick marks the wrapping cycle.
module modulo_contador_div #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tick
);

    assign tick = en && (cnt == W'(N - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/modulo_batalha_grid_ctrl.sv
// Battleship core: shot judgement FSM with shot limit, LED column scan and 7-seg digit multiplexing.
module modulo_batalha_grid_ctrl
    import modulo_batalha_grid_ctrl_pkg::*;
#(
    parameter int ROWS      = 7,
    parameter int COLS      = 5,
    parameter int RW        = 3,
    parameter int CW        = 3,
    parameter int MAX_SHOTS = 10,
    parameter int SCAN_DIV  = 1000,
    parameter int DIG_DIV   = 1000
) (
    input logic                      clk,
    input logic                      clr_n,
    modulo_batalha_grid_ctrl_if.slave bus
);

    localparam int NCELL = ROWS * COLS;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int COLW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW    = (DIG_DIV > 1) ? $clog2(DIG_DIV) : 1;

    // Button conditioning: sync stages then one edge-detect stage; the pulse is registered.
    logic [SYNC_DEPTH:0] confirm_sync, clear_sync;
    logic                confirm_p, clear_p;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            confirm_sync <= '0;
            clear_sync   <= '0;
            confirm_p    <= 1'b0;
            clear_p      <= 1'b0;
        end else begin
            confirm_sync <= {confirm_sync[SYNC_DEPTH-1:0], bus.confirm};
            clear_sync   <= {clear_sync[SYNC_DEPTH-1:0], bus.clear};
            confirm_p    <= confirm_sync[SYNC_DEPTH-1] & ~confirm_sync[SYNC_DEPTH];
            clear_p      <= clear_sync[SYNC_DEPTH-1] & ~clear_sync[SYNC_DEPTH];
        end
    end

    game_state_e      state_q, state_d;
    status_e          status_q, status_d;
    logic [7:0]       shots_q, shots_d;
    logic [NCELL-1:0] attacked_q, attacked_d;
    logic [RW-1:0]    last_row_q, last_row_d;
    logic [CW-1:0]    last_col_q, last_col_d;
    logic [IW-1:0]    tgt_bit;
    logic             coord_bad;

    assign tgt_bit   = IW'(cell_bit(ROWS, COLS, int'(bus.coord_row), int'(bus.coord_col)));
    assign coord_bad = (bus.coord_row == '0) || (bus.coord_row > RW'(ROWS)) ||
                       (bus.coord_col == '0) || (bus.coord_col > CW'(COLS));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= PLAY;
            status_q   <= ST_IDLE;
            shots_q    <= '0;
            attacked_q <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            shots_q    <= shots_d;
            attacked_q <= attacked_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        shots_d    = shots_q;
        attacked_d = attacked_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        if (clear_p) begin
            state_d    = PLAY;
            status_d   = ST_IDLE;
            shots_d    = '0;
            attacked_d = '0;
            last_row_d = '0;
            last_col_d = '0;
        end else if (confirm_p && state_q == PLAY) begin
            last_row_d = bus.coord_row;
            last_col_d = bus.coord_col;
            if (coord_bad) begin
                status_d = ST_INVALID;
            end else if (attacked_q[tgt_bit]) begin
                status_d = ST_REPEAT;
            end else begin
                attacked_d[tgt_bit] = 1'b1;
                shots_d             = shots_q + 8'd1;
                status_d            = bus.ship_map[tgt_bit] ? ST_HIT : ST_MISS;
                // The last ship cell sunk ends the game even on the final allowed shot.
                if (bus.ship_map[tgt_bit] && ((bus.ship_map & ~attacked_d) == '0) &&
                    (bus.ship_map != '0)) begin
                    status_d = ST_WIN;
                    state_d  = OVER;
                end else if (shots_d == 8'(MAX_SHOTS)) begin
                    status_d = ST_LOSE;
                    state_d  = OVER;
                end
            end
        end
    end

    logic            scan_tick, dig_tick, col_wrap_unused, dig_wrap_unused;
    logic [SW-1:0]   scan_pre_unused;
    logic [DW-1:0]   dig_pre_unused;
    logic [COLW-1:0] col_cnt;
    logic [1:0]      dig_cnt;

    modulo_contador_div #(.N(SCAN_DIV)) u_scan_pre (
        .clk(clk), .clr_n(clr_n), .en(1'b1), .cnt(scan_pre_unused), .tick(scan_tick)
    );
    modulo_contador_div #(.N(COLS)) u_col_cnt (
        .clk(clk), .clr_n(clr_n), .en(scan_tick), .cnt(col_cnt), .tick(col_wrap_unused)
    );
    modulo_contador_div #(.N(DIG_DIV)) u_dig_pre (
        .clk(clk), .clr_n(clr_n), .en(1'b1), .cnt(dig_pre_unused), .tick(dig_tick)
    );
    modulo_contador_div #(.N(NUM_DIGITS)) u_dig_cnt (
        .clk(clk), .clr_n(clr_n), .en(dig_tick), .cnt(dig_cnt), .tick(dig_wrap_unused)
    );

    logic [NCELL-1:0] view_map;
    logic [ROWS-1:0]  line_d;
    logic [3:0]       digit_d;

    always_comb begin
        view_map = bus.show_ships ? (bus.ship_map | attacked_q) : attacked_q;
        if (status_q == ST_WIN) view_map = bus.ship_map;
        line_d = '0;
        for (int r = 1; r <= ROWS; r++) begin
            line_d[r-1] = view_map[IW'(cell_bit(ROWS, COLS, r, int'(col_cnt) + 1))];
        end
        case (dig_cnt)
            2'd0:    digit_d = {1'b0, status_q};
            2'd1:    digit_d = 4'(last_row_q);
            2'd2:    digit_d = 4'(last_col_q);
            default: digit_d = '0;
        endcase
    end

    logic [COLS-1:0] m_col_q;
    logic [ROWS-1:0] m_line_q;
    logic [1:0]      digit_sel_q;
    logic [3:0]      digit_val_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_col_q     <= COLS'(1);
            m_line_q    <= '0;
            digit_sel_q <= '0;
            digit_val_q <= '0;
        end else begin
            m_col_q     <= COLS'(1) << col_cnt;
            m_line_q    <= line_d;
            digit_sel_q <= dig_cnt;
            digit_val_q <= digit_d;
        end
    end

    assign bus.m_col     = m_col_q;
    assign bus.m_line    = m_line_q;
    assign bus.digit_sel = digit_sel_q;
    assign bus.digit_val = digit_val_q;
    assign bus.status    = status_q;
    assign bus.shots     = shots_q;
    assign bus.game_over = (state_q == OVER);
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_modulo_batalha_grid_ctrl.sv
// Directed bench for the battleship core on a 7x5 board, 3-shot limit and fast scan/digit dividers.
module tb_modulo_batalha_grid_ctrl;
    import modulo_batalha_grid_ctrl_pkg::*;

    localparam int ROWS = 7, COLS = 5, RW = 4, CW = 4;
    localparam int MAX_SHOTS = 3, SCAN_DIV = 2, DIG_DIV = 3;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    modulo_batalha_grid_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) bif ();

    modulo_batalha_grid_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW),
        .MAX_SHOTS(MAX_SHOTS), .SCAN_DIV(SCAN_DIV), .DIG_DIV(DIG_DIV)
    ) dut (
        .clk(clk),
        .clr_n(clr_n),
        .bus(bif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] cell_mask(input int r, input int c);
        logic [34:0] m;
        m = '0;
        m[34 - ((r - 1) * 5 + (c - 1))] = 1'b1;
        return m;
    endfunction

    task automatic fire(input int r, input int c);
        @(negedge clk);
        bif.coord_row = RW'(r);
        bif.coord_col = CW'(c);
        bif.confirm   = 1'b1;
        repeat (4) @(negedge clk);
        bif.confirm = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_game(input bit with_confirm);
        @(negedge clk);
        bif.clear   = 1'b1;
        bif.confirm = with_confirm;
        repeat (4) @(negedge clk);
        bif.clear   = 1'b0;
        bif.confirm = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_col(input logic [4:0] want, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bif.m_col == want) found = 1'b1;
        end
        check({tag, "_col_seen"}, 32'(found), 32'd1);
    endtask

    task automatic check_digit(input logic [1:0] sel, input logic [3:0] exp, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bif.digit_sel == sel) found = 1'b1;
        end
        check({tag, "_sel_seen"}, 32'(found), 32'd1);
        check(tag, 32'(bif.digit_val), 32'(exp));
    endtask

    task automatic check_game(input string tag, input status_e st, input int sh, input bit over);
        check({tag, "_status"}, 32'(bif.status), 32'(st));
        check({tag, "_shots"}, 32'(bif.shots), 32'(sh));
        check({tag, "_over"}, 32'(bif.game_over), 32'(over));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bif.ship_map   = cell_mask(1, 1);
        bif.coord_row  = '0;
        bif.coord_col  = '0;
        bif.confirm    = 1'b0;
        bif.clear      = 1'b0;
        bif.show_ships = 1'b0;

        // 1: reset values, held and just after release
        repeat (3) @(negedge clk);
        check("rst_m_col", 32'(bif.m_col), 32'h01);
        check("rst_m_line", 32'(bif.m_line), 32'h00);
        check("rst_digit_sel", 32'(bif.digit_sel), 32'd0);
        check_game("rst", ST_IDLE, 0, 1'b0);
        clr_n = 1'b1;
        @(negedge clk);
        check("rel_m_col", 32'(bif.m_col), 32'h01);
        check("rel_digit_sel", 32'(bif.digit_sel), 32'd0);
        check("rel_status", 32'(bif.status), 32'(ST_IDLE));

        // 2: single-cell fleet sunk in one shot, with the k+3 latency
        @(negedge clk);
        bif.coord_row = 4'd1;
        bif.coord_col = 4'd1;
        bif.confirm   = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_k2_status", 32'(bif.status), 32'(ST_IDLE));
        @(negedge clk);
        check_game("win", ST_WIN, 1, 1'b1);
        bif.confirm = 1'b0;
        repeat (4) @(negedge clk);
        wait_col(5'b00001, "win_view");
        check("win_m_line", 32'(bif.m_line), 32'b0000001);
        fire(2, 2);
        check_game("over_ignore", ST_WIN, 1, 1'b1);
        check_digit(2'd1, 4'd1, "over_last_row");
        clear_game(1'b0);
        check_game("clr_after_win", ST_IDLE, 0, 1'b0);

        // 3: miss then repeat on an empty cell; ship overlay view
        bif.ship_map = cell_mask(4, 5);
        fire(2, 3);
        check_game("miss", ST_MISS, 1, 1'b0);
        wait_col(5'b00100, "miss_view");
        check("miss_m_line", 32'(bif.m_line), 32'b0000010);
        fire(2, 3);
        check_game("repeat", ST_REPEAT, 1, 1'b0);
        bif.show_ships = 1'b1;
        wait_col(5'b10000, "show_on");
        check("show_on_m_line", 32'(bif.m_line), 32'b0001000);
        bif.show_ships = 1'b0;
        wait_col(5'b10000, "show_off");
        check("show_off_m_line", 32'(bif.m_line), 32'b0000000);

        // 4: out-of-range coordinates
        clear_game(1'b0);
        fire(0, 3);
        check_game("inv_row0", ST_INVALID, 0, 1'b0);
        check_digit(2'd1, 4'd0, "inv_row0_row");
        check_digit(2'd2, 4'd3, "inv_row0_col");
        fire(8, 1);
        check_game("inv_row8", ST_INVALID, 0, 1'b0);
        check_digit(2'd0, 4'd4, "inv_row8_stat");
        check_digit(2'd1, 4'd8, "inv_row8_row");
        check_digit(2'd2, 4'd1, "inv_row8_col");
        fire(1, 6);
        check_game("inv_col6", ST_INVALID, 0, 1'b0);

        // 5: hit without win, then the shot limit, then clear beats confirm
        clear_game(1'b0);
        bif.ship_map = cell_mask(1, 1) | cell_mask(2, 2);
        fire(1, 1);
        check_game("hit", ST_HIT, 1, 1'b0);
        fire(3, 3);
        check_game("miss2", ST_MISS, 2, 1'b0);
        fire(4, 4);
        check_game("lose", ST_LOSE, 3, 1'b1);
        bif.coord_row = 4'd5;
        bif.coord_col = 4'd5;
        clear_game(1'b1);
        check_game("clr_conf", ST_IDLE, 0, 1'b0);
        check_digit(2'd1, 4'd0, "clr_conf_row");
        wait_col(5'b00001, "clr_conf_map");
        check("clr_conf_m_line", 32'(bif.m_line), 32'b0000000);

        // 6: scan cadence and wrap, then async reset mid-scan
        bif.ship_map = '0;
        fire(1, 1);
        check_game("pre_scan", ST_MISS, 1, 1'b0);
        wait_col(5'b01000, "scan_c3");
        wait_col(5'b10000, "scan_c4");
        @(negedge clk);
        check("scan_c4_hold", 32'(bif.m_col), 32'b10000);
        @(negedge clk);
        check("scan_wrap", 32'(bif.m_col), 32'b00001);
        @(negedge clk);
        check("scan_c0_hold", 32'(bif.m_col), 32'b00001);
        @(negedge clk);
        check("scan_c1", 32'(bif.m_col), 32'b00010);
        #2;
        clr_n = 1'b0;
        #1;
        check("async_m_col", 32'(bif.m_col), 32'b00001);
        check("async_shots", 32'(bif.shots), 32'd0);
        check("async_status", 32'(bif.status), 32'(ST_IDLE));
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
